bitwise_unit: RTL and testbench
===============================

# bitwise_unit

- Parametrised, registered successor to the team's two-input combinational AND cell.
- Applies one of eight bitwise operations to two `WIDTH`-bit operands per beat.
- Optionally folds a multi-beat chain into one accumulated result.
- Inputs and outputs use valid/ready streams; results leave through a 2-entry output FIFO.

## Interface
- `WIDTH`, 8: operand/result width in bits (≥1).
- `CNT_W`, 8: width of the beat counter reported per result (≥1).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset; one clock, reset is synchronous and active-low.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: beat accepted when `in_valid & in_ready` at a rising edge.
- `in_a` in `WIDTH`: operand A; used only on the first beat of a result.
- `in_b` in `WIDTH`: operand B.
- `in_op` in 3: operation; sampled on the first beat only.
- `in_acc` in 1: on a first beat, start an accumulation chain.
- `in_last` in 1: closes the chain; ignored when not accumulating.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_c` out `WIDTH`: result value.
- `out_zero` out 1: `out_c == 0`.
- `out_count` out `CNT_W`: number of beats folded into this result (saturating).

## Operation
- **Op codes:**
  - 0 AND; 1 OR; 2 XOR.
  - 3 NAND; 4 NOR; 5 XNOR.
  - 6 ANDN (x & ~b); 7 PASS (x).
- **FSM states:** IDLE and ACCUM.
- **IDLE, accepted beat:** `acc = f(in_a, in_b)` with `op = in_op`, `cnt = 1`.
  - `in_acc = 0` or `in_last = 1`: push {acc, cnt} to the FIFO; stay IDLE.
  - Otherwise: latch `op`, go to ACCUM.
- **ACCUM, accepted beat:** `acc = f(acc, in_b)` using the latched op; `cnt` increments, saturating at 2^CNT_W−1.
  - `in_a`, `in_op` and `in_acc` are ignored.
  - `in_last = 1`: push the result, return to IDLE.
- **Stall rule:** every beat, emitting or not, is stalled while the FIFO is full.
- **FIFO:** 2 entries, in order, no loss or duplication.
  - `out_valid` = FIFO not empty.
  - `out_c`, `out_zero`, `out_count` come from the head entry.
  - Head pops on `out_valid & out_ready`.
- **`out_zero`:** computed at push time and stored with the entry.

## Timing
- **While `rst_n` is low:**
  - `in_ready = 0`, `out_valid = 0`.
  - `out_c = 0`, `out_zero = 0`, `out_count = 0`.
  - FSM returns to IDLE; acc, op and cnt are cleared; FIFO is emptied.
- **After reset:** `in_ready = 1` on the first cycle after `rst_n` is sampled high.
- **Reset mid-chain:** the partial chain and all FIFO contents are discarded; no result is emitted for them.
- **Latency:** `out_valid` rises the cycle after the closing beat is accepted.
- **Throughput:** one beat/cycle while `out_ready` is held high.
- **`in_ready`:** registered, equal to `!full` of the current FIFO state.
  - No combinational path from `out_ready` to `in_ready`.
  - A pop in a full cycle reopens `in_ready` only in the next cycle.
- **Simultaneous push and pop when not full:** occupancy is unchanged and order is preserved.
- **Stall stability:** outputs are stable while `out_valid & !out_ready`.
- **Input holding:** the producer must hold its payload stable while `in_valid & !in_ready`.

## Structure
- **Package `bitwise_pkg`:**
  - `op_e` enum with the eight codes above.
  - `state_e` enum {IDLE, ACCUM}.
  - Function `apply_op(op, x, b)` returning `WIDTH` bits.
- **Sub-module `fifo2`:**
  - Parametrised 2-entry synchronous FIFO on {`out_c`, `out_zero`, `out_count`}.
  - Exposes registered `full` and `empty`.
  - Shares `clk` and `rst_n`.
- **Top module:** holds the FSM, accumulator, counter and handshake logic.

## Test plan
- **Reset:** hold `rst_n` low 3 cycles with `in_valid = 1`.
  - During reset: `in_ready = 0`, `out_valid = 0`, all outputs 0.
  - `in_ready = 1` the cycle after release.
- **Single ops:** `a = F0`, `b = 3C`, ops 0–7, `out_ready = 1`.
  - Results 30, FC, CC, CF, 03, 33, C0, F0 in order.
  - `out_count = 1` each; each result 1 cycle after its beat.
- **XOR chain:**
  - Beats: (a=01, b=02, acc=1), (b=04), (b=08, last=1).
  - One result: `out_c = 0F`, `out_count = 3`, `out_zero = 0`.
- **Zero flag:** AND of AA and 55 gives `out_c = 00`, `out_zero = 1`.
- **Backpressure:** `out_ready = 0`; offer 3 single OR beats with b = 01, 02, 04 and a = 00.
  - Two beats accepted; `in_ready` low from the cycle after the second acceptance.
  - Raise `out_ready`: 01, 02, then 04 drain in order.
  - Third beat is accepted only after `in_ready` reasserts.
- **Reset mid-chain:**
  - Stimulus: two AND acc beats, then `rst_n` low 1 cycle, then a single OR of 0F and F0.
  - Only one result appears: FF with `out_count = 1`.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared types and the operation table for bitwise_unit.
// apply_op works on MAX_W bits; callers narrow the result to their width.
package bitwise_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic logic [MAX_W-1:0] apply_op(
        input op_e              op,
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:  r = x & b;
            OP_OR:   r = x | b;
            OP_XOR:  r = x ^ b;
            OP_NAND: r = ~(x & b);
            OP_NOR:  r = ~(x | b);
            OP_XNOR: r = ~(x ^ b);
            OP_ANDN: r = x & ~b;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_unit_fifo2.sv
// Two-entry in-order FIFO with registered full/empty flags.
// Storage is cleared on reset so the head reads as zero.
module fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic [1:0]    w_cnt_nxt;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;
    assign w_cnt_nxt = r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    assign o_rdata   = r_mem[r_rp];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    // Pointer, occupancy and flag update; flags follow next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= ~r_wp;
            end
            if (w_do_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == 2'd2);
            r_empty <= (w_cnt_nxt == 2'd0);
        end
    end

endmodule

// File: rtl/bitwise_unit.sv
// Registered bitwise operator with optional multi-beat fold.
// Results are queued in a 2-entry FIFO; in_ready depends only on state.
module bitwise_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    localparam int DW = WIDTH + 1 + CNT_W;

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_live;

    op_e              w_op_sel;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_close;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_wdata;
    logic [DW-1:0]    w_rdata;

    // Datapath: first beat uses in_a/in_op, later beats fold into r_acc.
    always_comb begin
        w_op_sel  = (r_state == IDLE) ? op_e'(in_op) : r_op;
        w_x       = (r_state == IDLE) ? in_a : r_acc;
        w_acc_nxt = WIDTH'(apply_op(w_op_sel, MAX_W'(w_x), MAX_W'(in_b)));
        if (r_state == IDLE) begin
            w_cnt_nxt = CNT_W'(1);
            w_close   = !in_acc || in_last;
        end else begin
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            w_close   = in_last;
        end
    end

    // r_live keeps in_ready low through reset and its release cycle.
    assign in_ready  = r_live & ~w_full;
    assign w_fire    = in_valid & in_ready;
    assign w_push    = w_fire & w_close;
    assign w_pop     = out_valid & out_ready;
    assign w_wdata   = {w_acc_nxt, (w_acc_nxt == '0), w_cnt_nxt};
    assign out_valid = ~w_empty;
    assign {out_c, out_zero, out_count} = w_rdata;

    // Chain FSM with accumulator, beat counter and latched op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_AND;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_fire) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                if (r_state == IDLE) begin
                    if (!w_close) begin
                        r_state <= ACCUM;
                        r_op    <= w_op_sel;
                    end
                end else if (in_last) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_bitwise_unit.sv
// Self-checking bench for bitwise_unit (WIDTH=8, CNT_W=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_bitwise_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_c;
    logic       out_zero;
    logic [7:0] out_count;

    always #5 clk = ~clk;

    bitwise_unit #(
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    typedef struct packed {
        logic [7:0] c;
        logic       z;
        logic [7:0] n;
    } res_t;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;

    bit         m_accum = 0;
    logic [2:0] m_op;
    logic [7:0] m_acc;
    int         m_cnt;

    logic       s_fire, s_pop, s_ready, s_valid, s_z, s_have;
    logic [7:0] s_c, s_n;
    int         s_occ;
    res_t       s_exp;

    function automatic logic [7:0] ref_op(logic [2:0] op, logic [7:0] x, logic [7:0] b);
        case (op)
            3'd0: return x & b;
            3'd1: return x | b;
            3'd2: return x ^ b;
            3'd3: return ~(x & b);
            3'd4: return ~(x | b);
            3'd5: return ~(x ^ b);
            3'd6: return x & ~b;
            default: return x;
        endcase
    endfunction

    task model_push();
        res_t r;
        r.c = m_acc;
        r.z = (m_acc == 8'h00);
        r.n = 8'(m_cnt);
        q.push_back(r);
    endtask

    task model_beat(logic [7:0] a, logic [7:0] b, logic [2:0] op, logic acc, logic last);
        if (!m_accum) begin
            m_acc = ref_op(op, a, b);
            m_cnt = 1;
            if (acc && !last) begin
                m_accum = 1;
                m_op    = op;
            end else begin
                model_push();
            end
        end else begin
            m_acc = ref_op(m_op, m_acc, b);
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (last) begin
                model_push();
                m_accum = 0;
            end
        end
    endtask

    // One clock: drive, snapshot, advance the model, move to next negedge.
    task automatic step(logic v, logic [7:0] a, logic [7:0] b, logic [2:0] op,
                        logic acc, logic last, logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_acc    = acc;
        in_last   = last;
        out_ready = ordy;
        s_fire  = in_valid & in_ready;
        s_pop   = out_valid & out_ready;
        s_ready = in_ready;
        s_valid = out_valid;
        s_c     = out_c;
        s_z     = out_zero;
        s_n     = out_count;
        s_occ   = q.size();
        s_have  = 0;
        if (!rst_n) begin
            q.delete();
            m_accum = 0;
        end else begin
            if (s_pop && q.size() > 0) begin
                s_exp  = q.pop_front();
                s_have = 1;
            end
            if (s_fire) model_beat(a, b, op, acc, last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hFF, 8'hFF, 3'd1, 0, 0, 1);
            checks++;
            if (s_ready !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hs got ready=%b valid=%b need 0 0", s_ready, s_valid);
            end
            checks++;
            if (s_c !== 8'h00 || s_z !== 1'b0 || s_n !== 8'h00) begin
                failures++;
                $display("FAIL reset_out got c=%h z=%b n=%h need 00 0 00", s_c, s_z, s_n);
            end
        end
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b need 1 0", s_ready, s_valid);
        end
    endtask

    task automatic test_single_ops();
        logic [7:0] exp[8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
        for (int k = 0; k < 9; k++) begin
            step(k < 8, 8'hF0, 8'h3C, 3'(k), 0, 0, 1);
            if (k < 8) begin
                checks++;
                if (s_fire !== 1'b1) begin
                    failures++;
                    $display("FAIL single_accept op=%0d got fire=%b need 1", k, s_fire);
                end
            end
            if (k > 0) begin
                checks++;
                if (s_valid !== 1'b1 || s_c !== exp[k-1] || s_n !== 8'h01) begin
                    failures++;
                    $display("FAIL single_op%0d got v=%b c=%h n=%h need 1 %h 01",
                             k - 1, s_valid, s_c, s_n, exp[k-1]);
                end
            end
        end
    endtask

    task automatic test_xor_chain();
        step(1, 8'h01, 8'h02, 3'd2, 1, 0, 1);
        step(1, 8'($urandom), 8'h04, 3'($urandom), 1'($urandom), 0, 1);
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL chain_early got valid=%b need 0", s_valid);
        end
        step(1, 8'($urandom), 8'h08, 3'($urandom), 1'($urandom), 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b1 || s_c !== 8'h0F || s_n !== 8'd3 || s_z !== 1'b0) begin
            failures++;
            $display("FAIL xor_chain got v=%b c=%h n=%h z=%b need 1 0f 03 0",
                     s_valid, s_c, s_n, s_z);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL chain_single got valid=%b need 0", s_valid);
        end
    endtask

    task automatic test_zero_flag();
        step(1, 8'hAA, 8'h55, 3'd0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b1 || s_c !== 8'h00 || s_z !== 1'b1) begin
            failures++;
            $display("FAIL zero_flag got v=%b c=%h z=%b need 1 00 1", s_valid, s_c, s_z);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bs[3] = '{8'h01, 8'h02, 8'h04};
        int k = 0;
        int cyc = 0;
        while (k < 2 && cyc < 10) begin
            step(1, 8'h00, bs[k], 3'd1, 0, 0, 0);
            if (s_fire) k++;
            cyc++;
        end
        checks++;
        if (k != 2 || cyc != 2) begin
            failures++;
            $display("FAIL bp_accept got accepted=%0d cycles=%0d need 2 2", k, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h00, bs[2], 3'd1, 0, 0, 0);
            checks++;
            if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_c !== 8'h01) begin
                failures++;
                $display("FAIL bp_stall got ready=%b v=%b c=%h need 0 1 01",
                         s_ready, s_valid, s_c);
            end
        end
        step(1, 8'h00, bs[2], 3'd1, 0, 0, 1);
        checks++;
        if (s_ready !== 1'b0 || s_pop !== 1'b1 || s_c !== 8'h01) begin
            failures++;
            $display("FAIL bp_pop1 got ready=%b pop=%b c=%h need 0 1 01", s_ready, s_pop, s_c);
        end
        step(1, 8'h00, bs[2], 3'd1, 0, 0, 1);
        checks++;
        if (s_ready !== 1'b1 || s_fire !== 1'b1 || s_c !== 8'h02) begin
            failures++;
            $display("FAIL bp_pop2 got ready=%b fire=%b c=%h need 1 1 02", s_ready, s_fire, s_c);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b1 || s_c !== 8'h04 || s_n !== 8'h01) begin
            failures++;
            $display("FAIL bp_pop3 got v=%b c=%h n=%h need 1 04 01", s_valid, s_c, s_n);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got valid=%b need 0", s_valid);
        end
    endtask

    task automatic test_saturation();
        int early = 0;
        step(1, 8'h5A, 8'($urandom), 3'd7, 1, 0, 1);
        for (int i = 0; i < 298; i++) begin
            step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 0, 1);
            if (s_valid) early++;
        end
        step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1, 1);
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL sat_early got results=%0d need 0", early);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (s_valid !== 1'b1 || s_c !== 8'h5A || s_n !== 8'hFF || s_z !== 1'b0) begin
            failures++;
            $display("FAIL sat_count got v=%b c=%h n=%h z=%b need 1 5a ff 0",
                     s_valid, s_c, s_n, s_z);
        end
    endtask

    task automatic test_reset_mid_chain();
        int fired = 0;
        int pops = 0;
        logic [7:0] first_c = 8'hXX;
        logic [7:0] first_n = 8'hXX;
        step(1, 8'hFF, 8'h0F, 3'd0, 1, 0, 1);
        step(1, 8'h00, 8'hF3, 3'd0, 1, 0, 1);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 6 && fired == 0; i++) begin
            step(1, 8'h0F, 8'hF0, 3'd1, 0, 0, 1);
            if (s_fire) fired = 1;
            if (s_pop) pops++;
        end
        checks++;
        if (fired != 1) begin
            failures++;
            $display("FAIL rmc_accept got accepted=%0d need 1", fired);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            if (s_pop) begin
                if (pops == 0) begin
                    first_c = s_c;
                    first_n = s_n;
                end
                pops++;
            end
        end
        checks++;
        if (pops != 1 || first_c !== 8'hFF || first_n !== 8'h01) begin
            failures++;
            $display("FAIL rmc_result got pops=%0d c=%h n=%h need 1 ff 01",
                     pops, first_c, first_n);
        end
    endtask

    task automatic test_random();
        logic       v = 0;
        logic [7:0] a, b;
        logic [2:0] op;
        logic       acc, last;
        int         bad = 0;
        for (int i = 0; i < 600; i++) begin
            if (!v || s_fire) begin
                v    = ($urandom % 4) != 0;
                a    = 8'($urandom);
                b    = 8'($urandom);
                op   = 3'($urandom);
                acc  = ($urandom % 3) == 0;
                last = ($urandom % 3) == 0;
            end
            step(v, a, b, op, acc, last, ($urandom % 4) != 0);
            checks++;
            if (s_ready !== (s_occ < 2) || s_valid !== (s_occ > 0)) begin
                failures++;
                $display("FAIL rnd_flags cyc=%0d got ready=%b valid=%b need occupancy %0d",
                         i, s_ready, s_valid, s_occ);
            end
            if (s_pop) begin
                checks++;
                if (!s_have) begin
                    failures++;
                    $display("FAIL rnd_extra cyc=%0d got c=%h need no result", i, s_c);
                end else if (s_c !== s_exp.c || s_z !== s_exp.z || s_n !== s_exp.n) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got c=%h z=%b n=%h need %h %b %h",
                             i, s_c, s_z, s_n, s_exp.c, s_exp.z, s_exp.n);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            if (s_pop && (!s_have || s_c !== s_exp.c || s_n !== s_exp.n)) bad++;
        end
        checks++;
        if (bad != 0 || q.size() != 0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain got bad=%0d left=%0d valid=%b need 0 0 0",
                     bad, q.size(), s_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        s_fire    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_xor_chain();
        test_zero_flag();
        test_backpressure();
        test_saturation();
        test_reset_mid_chain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
